// File: rtl/spm_bank_conflict_serializer_if.sv
// Request/issue bus of the SPM bank-conflict serializer.
// master = address-decode side driving requests, slave = serializer.
interface spm_bank_conflict_serializer_if #(
  parameter int unsigned NUM_LANES    = 16,
  parameter int unsigned NUM_BANKS    = 16,
  parameter int unsigned ENTRY_ADDR_W = 10
);
  localparam int unsigned BANK_ADDR_W = $clog2(NUM_BANKS);

  logic                                 req_valid;
  logic                                 req_ready;
  logic                                 req_is_store;
  logic [NUM_LANES-1:0]                 req_mask;
  logic [NUM_LANES*BANK_ADDR_W-1:0]     req_bank_index;
  logic [NUM_LANES*ENTRY_ADDR_W-1:0]    req_bank_offset;

  logic                                 issue_valid;
  logic                                 issue_ready;
  logic [NUM_LANES-1:0]                 issue_mask;
  logic [NUM_BANKS-1:0]                 issue_bank_en;
  logic                                 issue_is_store;
  logic                                 issue_last;
  logic                                 busy;

  modport master (
    output req_valid, req_is_store, req_mask, req_bank_index, req_bank_offset, issue_ready,
    input  req_ready, issue_valid, issue_mask, issue_bank_en, issue_is_store, issue_last, busy
  );

  modport slave (
    input  req_valid, req_is_store, req_mask, req_bank_index, req_bank_offset, issue_ready,
    output req_ready, issue_valid, issue_mask, issue_bank_en, issue_is_store, issue_last, busy
  );
endinterface

// File: rtl/spm_bank_conflict_serializer.sv
// Serializes one multi-lane SPM request into bank-conflict-free issue groups (loads broadcast).
// Optional SPM_STORE_COALESCE_EN: same-address store lanes retire together, highest lane writes.
module spm_bank_conflict_serializer #(
  parameter int unsigned NUM_LANES    = 16,
  parameter int unsigned NUM_BANKS    = 16,
  parameter int unsigned ENTRY_ADDR_W = 10
) (
  input  logic clk,
  input  logic reset_n,
  spm_bank_conflict_serializer_if.slave bus
);
  localparam int unsigned BANK_ADDR_W = $clog2(NUM_BANKS);
  localparam int unsigned LANE_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [0:0] {IDLE, ISSUE} state_t;

  state_t                    state_q, state_d;
  logic [NUM_LANES-1:0]      pending_q, pending_d;
  logic                      store_q, store_d;
  logic [BANK_ADDR_W-1:0]    idx_q [NUM_LANES];
  logic [BANK_ADDR_W-1:0]    idx_d [NUM_LANES];
  logic [ENTRY_ADDR_W-1:0]   off_q [NUM_LANES];
  logic [ENTRY_ADDR_W-1:0]   off_d [NUM_LANES];

  logic                      issue_valid_q;
  logic [NUM_LANES-1:0]      issue_mask_q;
  logic [NUM_BANKS-1:0]      issue_bank_en_q;
  logic [NUM_LANES-1:0]      retired_q;
  logic                      issue_last_q;
  logic                      busy_q;
  logic                      req_ready_q;

  logic [NUM_LANES-1:0]      is_winner;
  logic [NUM_LANES-1:0]      same_addr;
  logic [NUM_LANES-1:0]      grp_mask;
  logic [NUM_LANES-1:0]      grp_retired;
  logic [NUM_BANKS-1:0]      grp_bank_en;
  logic                      grp_last;

  // Next-state: latch a request in IDLE, retire the presented group on issue_ready.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    store_d   = store_q;
    idx_d     = idx_q;
    off_d     = off_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && (bus.req_mask != '0)) begin
          store_d   = bus.req_is_store;
          pending_d = bus.req_mask;
          for (int i = 0; i < NUM_LANES; i++) begin
            idx_d[i] = bus.req_bank_index[i*BANK_ADDR_W +: BANK_ADDR_W];
            off_d[i] = bus.req_bank_offset[i*ENTRY_ADDR_W +: ENTRY_ADDR_W];
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.issue_ready) begin
          pending_d = pending_q & ~retired_q;
          if (pending_d == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Group for the next cycle, built from next-state pending so outputs can be registered.
  always_comb begin
    logic                 found;
    logic [LANE_W-1:0]    wl;
    is_winner   = '0;
    same_addr   = '0;
    grp_bank_en = '0;
    found       = 1'b0;
    wl          = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      found = 1'b0;
      wl    = '0;
      for (int j = 0; j < NUM_LANES; j++) begin
        if ((j <= i) && !found && pending_d[j] && (idx_d[j] == idx_d[i])) begin
          found = 1'b1;
          wl    = LANE_W'(j);
        end
      end
      same_addr[i] = pending_d[i] && (off_d[wl] == off_d[i]);
      is_winner[i] = pending_d[i] && (wl == LANE_W'(i));
      if (is_winner[i]) grp_bank_en[idx_d[i]] = 1'b1;
    end
  end

`ifdef SPM_STORE_COALESCE_EN
  logic [NUM_LANES-1:0] coalesce_mask;

  // Among lanes sharing a winner's address, only the highest lane performs the write.
  always_comb begin
    coalesce_mask = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      coalesce_mask[i] = same_addr[i];
      for (int k = 0; k < NUM_LANES; k++) begin
        if ((k > i) && same_addr[k] && (idx_d[k] == idx_d[i])) coalesce_mask[i] = 1'b0;
      end
    end
  end

  always_comb begin
    grp_mask    = store_d ? coalesce_mask : same_addr;
    grp_retired = same_addr;
  end
`else
  always_comb begin
    grp_mask    = store_d ? is_winner : same_addr;
    grp_retired = grp_mask;
  end
`endif

  assign grp_last = ((pending_d & ~grp_retired) == '0);

  // State, request context and registered issue outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      pending_q       <= '0;
      store_q         <= 1'b0;
      idx_q           <= '{default: '0};
      off_q           <= '{default: '0};
      issue_valid_q   <= 1'b0;
      issue_mask_q    <= '0;
      issue_bank_en_q <= '0;
      retired_q       <= '0;
      issue_last_q    <= 1'b0;
      busy_q          <= 1'b0;
      req_ready_q     <= 1'b1;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      store_q         <= store_d;
      idx_q           <= idx_d;
      off_q           <= off_d;
      issue_valid_q   <= (state_d == ISSUE);
      issue_mask_q    <= (state_d == ISSUE) ? grp_mask    : '0;
      issue_bank_en_q <= (state_d == ISSUE) ? grp_bank_en : '0;
      retired_q       <= (state_d == ISSUE) ? grp_retired : '0;
      issue_last_q    <= (state_d == ISSUE) && grp_last;
      busy_q          <= (state_d != IDLE);
      req_ready_q     <= (state_d == IDLE);
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.issue_valid    = issue_valid_q;
  assign bus.issue_mask     = issue_mask_q;
  assign bus.issue_bank_en  = issue_bank_en_q;
  assign bus.issue_is_store = store_q;
  assign bus.issue_last     = issue_last_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_spm_bank_conflict_serializer.sv
// Scoreboard bench for spm_bank_conflict_serializer: directed requests push expected groups,
// a negedge monitor pops and compares each accepted issue group.
module tb_spm_bank_conflict_serializer;
  localparam int unsigned NL = 16;
  localparam int unsigned NB = 16;
  localparam int unsigned EW = 10;
  localparam int unsigned BW = 4;

  typedef struct packed {
    logic [15:0] mask;
    logic [15:0] en;
    logic        st;
    logic        last;
  } exp_t;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;
  exp_t sb [$];

  logic [NL*BW-1:0] idx_v;
  logic [NL*EW-1:0] off_v;

  spm_bank_conflict_serializer_if #(.NUM_LANES(NL), .NUM_BANKS(NB), .ENTRY_ADDR_W(EW)) bus ();

  spm_bank_conflict_serializer #(.NUM_LANES(NL), .NUM_BANKS(NB), .ENTRY_ADDR_W(EW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] m, input logic [15:0] en, input logic st, input logic last);
    exp_t e;
    e.mask = m; e.en = en; e.st = st; e.last = last;
    sb.push_back(e);
  endtask

  task automatic set_lane(input int lane, input int bank, input int off);
    idx_v[lane*BW +: BW] = BW'(bank);
    off_v[lane*EW +: EW] = EW'(off);
  endtask

  // Monitor: every accepted group is compared against the oldest expected group.
  always @(negedge clk) begin
    if (reset_n && bus.issue_valid && bus.issue_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_issue: got mask %h expected no issue", bus.issue_mask);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("issue_mask", 32'(bus.issue_mask), 32'(e.mask));
        chk("issue_bank_en", 32'(bus.issue_bank_en), 32'(e.en));
        chk("issue_is_store", 32'(bus.issue_is_store), 32'(e.st));
        chk("issue_last", 32'(bus.issue_last), 32'(e.last));
        if (e.last) chk("req_ready_during_last", 32'(bus.req_ready), 32'd0);
      end
    end
  end

  // Present one request, then wait for the serializer to drain; ngroups is the expected cycle count.
  task automatic send(input logic st, input logic [15:0] m, input int ngroups);
    int n;
    n = 0;
    while (!bus.req_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
    bus.req_valid       = 1'b1;
    bus.req_is_store    = st;
    bus.req_mask        = m;
    bus.req_bank_index  = idx_v;
    bus.req_bank_offset = off_v;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("first_valid", 32'(bus.issue_valid), 32'(m != 16'h0));
    chk("busy_after_accept", 32'(bus.busy), 32'(m != 16'h0));
    n = 0;
    while (bus.busy && n < 100) begin @(posedge clk); #1; n++; end
    chk("drain_cycles", 32'(n), 32'(ngroups));
    chk("idle_ready", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n             = 1'b0;
    bus.req_valid       = 1'b0;
    bus.req_is_store    = 1'b0;
    bus.req_mask        = '0;
    bus.req_bank_index  = '0;
    bus.req_bank_offset = '0;
    bus.issue_ready     = 1'b1;
    idx_v = '0;
    off_v = '0;
    #12;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_mask", 32'(bus.issue_mask), 32'd0);
    chk("rst_bank_en", 32'(bus.issue_bank_en), 32'd0);
    chk("rst_last", 32'(bus.issue_last), 32'd0);
    chk("rst_is_store", 32'(bus.issue_is_store), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Load: each lane its own bank, offset 5.
    for (int i = 0; i < 16; i++) set_lane(i, i, 5);
    push(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    send(1'b0, 16'hFFFF, 1);

    // Load broadcast: all lanes bank 3 offset 7.
    for (int i = 0; i < 16; i++) set_lane(i, 3, 7);
    push(16'hFFFF, 16'h0008, 1'b0, 1'b1);
    send(1'b0, 16'hFFFF, 1);

    // Store: lanes 0..2 bank 2, distinct offsets.
    idx_v = '0; off_v = '0;
    for (int i = 0; i < 3; i++) set_lane(i, 2, i);
    push(16'h0001, 16'h0004, 1'b1, 1'b0);
    push(16'h0002, 16'h0004, 1'b1, 1'b0);
    push(16'h0004, 16'h0004, 1'b1, 1'b1);
    send(1'b1, 16'h0007, 3);

    // Store: lanes 4 and 9 to the same bank+offset.
    idx_v = '0; off_v = '0;
    set_lane(4, 1, 3);
    set_lane(9, 1, 3);
`ifdef SPM_STORE_COALESCE_EN
    push(16'h0200, 16'h0002, 1'b1, 1'b1);
    send(1'b1, 16'h0210, 1);
`else
    push(16'h0010, 16'h0002, 1'b1, 1'b0);
    push(16'h0200, 16'h0002, 1'b1, 1'b1);
    send(1'b1, 16'h0210, 2);
`endif

    // Mixed load: partial broadcast in bank 0 plus an independent bank 5 lane.
    idx_v = '0; off_v = '0;
    set_lane(0, 0, 1); set_lane(1, 0, 1); set_lane(2, 0, 2); set_lane(3, 0, 1);
    set_lane(4, 5, 0);
    push(16'h001B, 16'h0021, 1'b0, 1'b0);
    push(16'h0004, 16'h0001, 1'b0, 1'b1);
    send(1'b0, 16'h001F, 2);

    // Worst case: all lanes bank 0 at distinct offsets, one lane per group.
    for (int i = 0; i < 16; i++) set_lane(i, 0, i);
    for (int i = 0; i < 16; i++) push(16'(1 << i), 16'h0001, 1'b0, 1'b1 ? (i == 15) : 1'b0);
    send(1'b0, 16'hFFFF, 16);

    // Empty mask is consumed without issuing; next request accepted right after.
    send(1'b0, 16'h0000, 0);
    chk("zero_mask_no_valid", 32'(bus.issue_valid), 32'd0);
    for (int i = 0; i < 16; i++) set_lane(i, i, 5);
    push(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    send(1'b0, 16'hFFFF, 1);

    // Stall with issue_ready low, then reset mid-request.
    idx_v = '0; off_v = '0;
    for (int i = 0; i < 3; i++) set_lane(i, 2, i);
    bus.issue_ready     = 1'b0;
    bus.req_valid       = 1'b1;
    bus.req_is_store    = 1'b1;
    bus.req_mask        = 16'h0007;
    bus.req_bank_index  = idx_v;
    bus.req_bank_offset = off_v;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.issue_valid), 32'd1);
      chk("hold_mask", 32'(bus.issue_mask), 32'h0001);
      chk("hold_bank_en", 32'(bus.issue_bank_en), 32'h0004);
      chk("hold_last", 32'(bus.issue_last), 32'd0);
      chk("hold_is_store", 32'(bus.issue_is_store), 32'd1);
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.issue_valid), 32'd0);
    chk("mid_rst_mask", 32'(bus.issue_mask), 32'd0);
    chk("mid_rst_bank_en", 32'(bus.issue_bank_en), 32'd0);
    chk("mid_rst_last", 32'(bus.issue_last), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_is_store", 32'(bus.issue_is_store), 32'd0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    reset_n         = 1'b1;
    bus.issue_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", 32'(bus.busy), 32'd0);

    // Request after reset runs normally.
    for (int i = 0; i < 16; i++) set_lane(i, 3, 7);
    push(16'hFFFF, 16'h0008, 1'b0, 1'b1);
    send(1'b0, 16'hFFFF, 1);

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
